// File: rtl/spi_slave_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_fifo
// Description : SPI slave exchanging fixed-length LSB-first frames with a host
//               master. Received words are queued in an RX FIFO (first-word
//               fall-through); transmit words are drawn from a TX FIFO through
//               a holding register that is sent once per frame.
// Ports       : clk, reset (async, active low)
//               SPI_SCK, SPI_SS, SPI_MOSI  - host SPI inputs (async to clk)
//               SPI_MISO                   - registered serial data out
//               wr_en, wr_data, wr_full    - TX FIFO write side
//               rd_valid, rd_ack, rd_data  - RX FIFO read side
//               rx_drop_count              - saturating count of dropped frames
// Options     : SPI_SLAVE_INIT_EN - adds an INIT state that needs an opcode
//               8'h01 frame before any data is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_fifo #(
    parameter int FRAME_BITS = 264,
    parameter int RX_WIDTH   = 32,
    parameter int TX_WIDTH   = 256,
    parameter int RX_DEPTH   = 4,
    parameter int TX_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SPI_SCK,
    input  logic                SPI_SS,
    input  logic                SPI_MOSI,
    output logic                SPI_MISO,
    input  logic                wr_en,
    input  logic [TX_WIDTH-1:0] wr_data,
    output logic                wr_full,
    output logic                rd_valid,
    input  logic                rd_ack,
    output logic [RX_WIDTH-1:0] rd_data,
    output logic [7:0]          rx_drop_count
);
    localparam int c_CNT_W = $clog2(FRAME_BITS + 1);
    localparam int c_RXA_W = $clog2(RX_DEPTH);
    localparam int c_TXA_W = $clog2(TX_DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(FRAME_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_RX_END   = c_CNT_W'(RX_WIDTH);
    localparam logic [c_CNT_W-1:0] c_STAT_RX  = c_CNT_W'(5);   // drives frame bit 6
    localparam logic [c_CNT_W-1:0] c_STAT_TX  = c_CNT_W'(6);   // drives frame bit 7
    localparam logic [c_CNT_W-1:0] c_DATA_LO  = c_CNT_W'(7);   // drives frame bit 8
    localparam logic [c_CNT_W-1:0] c_DATA_END = c_CNT_W'(7 + TX_WIDTH);
    localparam logic [c_RXA_W:0]   c_RX_FULL  = (c_RXA_W + 1)'(RX_DEPTH);
    localparam logic [c_TXA_W:0]   c_TX_FULL  = (c_TXA_W + 1)'(TX_DEPTH);

    // ---------------- input synchronisers and edge detect ----------------
    logic [2:0] r_sck_sync;
    logic [2:0] r_ss_sync;
    logic [1:0] r_mosi_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], SPI_SCK};
            r_ss_sync   <= {r_ss_sync[1:0], SPI_SS};
            r_mosi_sync <= {r_mosi_sync[0], SPI_MOSI};
        end
    end

    logic w_sck_rise, w_ss_edge, w_mosi;
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_ss_edge  = r_ss_sync[1] ^ r_ss_sync[2];
    assign w_mosi     = r_mosi_sync[1];

    // ---------------- frame tracking ----------------
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic                r_miso, r_rx_ok, r_tx_ok;
    logic [RX_WIDTH-1:0] r_rx_sh;
    logic [TX_WIDTH-1:0] r_tx_sh;     // per-frame copy, so an abort keeps r_tx_data intact
    logic [TX_WIDTH-1:0] r_tx_data;
    logic                r_tx_loaded;
    logic                w_active;

    logic w_edge_ok, w_frame_start, w_frame_done, w_rx_shift, w_in_data;
    logic [RX_WIDTH-1:0] w_rx_word;
    assign w_edge_ok     = w_sck_rise & ~w_ss_edge;   // SS edge wins over a coincident SCK edge
    assign w_frame_start = w_edge_ok & (r_bit_cnt == '0);
    assign w_frame_done  = w_edge_ok & (r_bit_cnt == c_LAST);
    assign w_rx_shift    = w_edge_ok & (r_bit_cnt < c_RX_END);
    assign w_in_data     = (r_bit_cnt >= c_DATA_LO) && (r_bit_cnt < c_DATA_END);
    // Word as it will look after this edge's shift, so the push sees the final bit.
    assign w_rx_word     = w_rx_shift ? {w_mosi, r_rx_sh[RX_WIDTH-1:1]} : r_rx_sh;

    logic w_rx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            r_rx_ok   <= 1'b0;
            r_tx_ok   <= 1'b0;
            r_rx_sh   <= '0;
            r_tx_sh   <= '0;
        end else if (w_ss_edge) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
        end else if (w_sck_rise) begin
            r_bit_cnt <= (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + 1'b1;
            if (w_frame_start) begin
                r_rx_ok <= ~w_rx_full;
                r_tx_ok <= r_tx_loaded & w_active;
                r_tx_sh <= r_tx_data;
            end
            if (w_rx_shift)
                r_rx_sh <= w_rx_word;
            // MISO carries frame bit c+1 after the edge with bit_cnt == c
            if (r_bit_cnt == c_STAT_RX)
                r_miso <= r_rx_ok | ~w_active;
            else if (r_bit_cnt == c_STAT_TX)
                r_miso <= r_tx_ok;
            else if (w_in_data) begin
                r_miso  <= r_tx_ok & r_tx_sh[0];
                r_tx_sh <= r_tx_sh >> 1;
            end else
                r_miso <= 1'b0;
        end
    end

    assign SPI_MISO = r_miso;

    // ---------------- optional INIT gating ----------------
`ifdef SPI_SLAVE_INIT_EN
    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_ACTIVE = 1'b1} state_t;
    state_t r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_INIT;
        else if (r_state == ST_INIT && w_frame_done && w_rx_word[7:0] == 8'h01)
            r_state <= ST_ACTIVE;
    end

    assign w_active = (r_state == ST_ACTIVE);
`else
    assign w_active = 1'b1;
`endif

    // ---------------- RX FIFO ----------------
    logic [RX_WIDTH-1:0] r_rx_mem [RX_DEPTH];
    logic [c_RXA_W-1:0]  r_rx_wp, r_rx_rp;
    logic [c_RXA_W:0]    r_rx_cnt;
    logic                w_rx_push, w_rx_pop;

    assign w_rx_push = w_frame_done & r_rx_ok & w_active;
    assign w_rx_pop  = rd_ack & rd_valid;
    assign w_rx_full = (r_rx_cnt == c_RX_FULL);
    assign rd_valid  = (r_rx_cnt != '0);
    assign rd_data   = rd_valid ? r_rx_mem[r_rx_rp] : '0;

    always_ff @(posedge clk) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wp] <= w_rx_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wp       <= '0;
            r_rx_rp       <= '0;
            r_rx_cnt      <= '0;
            rx_drop_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && !w_rx_pop)
                r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop)
                r_rx_cnt <= r_rx_cnt - 1'b1;
            if (w_frame_done && !r_rx_ok && rx_drop_count != 8'hFF)
                rx_drop_count <= rx_drop_count + 1'b1;
        end
    end

    // ---------------- TX FIFO and holding register ----------------
    logic [TX_WIDTH-1:0] r_tx_mem [TX_DEPTH];
    logic [c_TXA_W-1:0]  r_tx_wp, r_tx_rp;
    logic [c_TXA_W:0]    r_tx_cnt;
    logic                w_tx_push, w_tx_load;

    assign wr_full   = (r_tx_cnt == c_TX_FULL);
    assign w_tx_push = wr_en & ~wr_full;
    // Reload only between frames and never on the cycle a frame could start.
    assign w_tx_load = ~r_tx_loaded & (r_tx_cnt != '0) & (r_bit_cnt == '0) & ~w_sck_rise;

    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wp     <= '0;
            r_tx_rp     <= '0;
            r_tx_cnt    <= '0;
            r_tx_loaded <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_load) r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_push && !w_tx_load)
                r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_load)
                r_tx_cnt <= r_tx_cnt - 1'b1;
            if (w_tx_load) begin
                r_tx_loaded <= 1'b1;
                r_tx_data   <= r_tx_mem[r_tx_rp];
            end else if (w_frame_done && r_tx_ok)
                r_tx_loaded <= 1'b0;
        end
    end

endmodule
`default_nettype wire
